// File: rtl/bullet_hit_detector.sv
// Purpose: bullet/heart overlap detector owning heart HP, post-hit invincibility and death flag.
// Latency: inputs registered at edge N, overlap at N+1, isCollide pulse registered at N+2.
// Backpressure: none; one sample per clock, isRun=0 freezes hit detection and the cooldown count.
// Optional feature: define BLUE_SAFE_EN so blue bullets hurt only while the heart is moving.
module bullet_hit_detector #(
    parameter logic [7:0]  HP_INIT         = 8'd20,
    parameter logic [7:0]  DAMAGE          = 8'd1,
    parameter logic [15:0] COOLDOWN_CYCLES = 16'd50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isRun,
    input  logic [15:0] heartPosition,
    input  logic [15:0] heartSize,
    input  logic        heartMoving,
    input  logic [15:0] position1,
    input  logic [15:0] size1,
    input  logic [2:0]  color1,
    input  logic        isRender1,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic [2:0]  color2,
    input  logic        isRender2,
    output logic        isCollide,
    output logic [1:0]  hitWhich,
    output logic [7:0]  hp,
    output logic        isInvincible,
    output logic        isDead
);

    // Axis-aligned box: top-left corner plus width/height, 8 bits each.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
    } box_t;

    // One bullet slot as seen by the detector.
    typedef struct packed {
        box_t       box;
        logic [2:0] color;
        logic       render;
    } bullet_t;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_DEAD     = 2'd2
    } state_t;

    localparam logic [2:0] COLOR_GREEN = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;

    // Stage 1: registered copies of every heart/bullet input.
    box_t    heart_q;
    logic    heart_moving_q;
    bullet_t blt1_q;
    bullet_t blt2_q;

    // Stage 2: registered per-slot overlap flags.
    logic    ov1_q;
    logic    ov2_q;

    state_t      state;
    logic [15:0] cool_cnt;

    // Strict-inequality box intersection. Right/bottom edges are formed
    // with 9-bit sums so boxes near coordinate 255 do not wrap around.
    function automatic logic boxes_overlap(input box_t b, input box_t hb);
        logic [8:0] b_right;
        logic [8:0] b_bottom;
        logic [8:0] h_right;
        logic [8:0] h_bottom;
        logic       nonzero;
        b_right  = {1'b0, b.x}  + {1'b0, b.w};
        b_bottom = {1'b0, b.y}  + {1'b0, b.h};
        h_right  = {1'b0, hb.x} + {1'b0, hb.w};
        h_bottom = {1'b0, hb.y} + {1'b0, hb.h};
        nonzero  = (b.w != 8'd0) && (b.h != 8'd0) && (hb.w != 8'd0) && (hb.h != 8'd0);
        return nonzero
            && ({1'b0, b.x}  < h_right)  && ({1'b0, hb.x} < b_right)
            && ({1'b0, b.y}  < h_bottom) && ({1'b0, hb.y} < b_bottom);
    endfunction

    // A slot hurts only when live, not green and geometrically overlapping.
    function automatic logic slot_hits(input bullet_t b, input box_t hb, input logic moving);
        logic hit;
        hit = b.render && (b.color != COLOR_GREEN) && boxes_overlap(b.box, hb);
`ifdef BLUE_SAFE_EN
        if ((b.color == COLOR_BLUE) && !moving) begin
            hit = 1'b0;
        end
`else
        if (b.color == COLOR_BLUE) begin
            hit = hit && (moving || !moving);
        end
`endif
        return hit;
    endfunction

    // Stage 1: capture the raw interface every cycle, independent of isRun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heart_q        <= '0;
            heart_moving_q <= 1'b0;
            blt1_q         <= '0;
            blt2_q         <= '0;
        end else begin
            heart_q        <= {heartPosition, heartSize};
            heart_moving_q <= heartMoving;
            blt1_q         <= {position1, size1, color1, isRender1};
            blt2_q         <= {position2, size2, color2, isRender2};
        end
    end

    // Stage 2: per-slot overlap evaluated on the stage-1 snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov1_q <= 1'b0;
            ov2_q <= 1'b0;
        end else begin
            ov1_q <= slot_hits(blt1_q, heart_q, heart_moving_q);
            ov2_q <= slot_hits(blt2_q, heart_q, heart_moving_q);
        end
    end

    // Hit FSM: one pulse per armed period, HP bookkeeping, invincibility and death.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ARMED;
            cool_cnt     <= 16'd0;
            isCollide    <= 1'b0;
            hitWhich     <= 2'b00;
            hp           <= HP_INIT;
            isInvincible <= 1'b0;
            isDead       <= 1'b0;
        end else begin
            isCollide <= 1'b0;
            case (state)
                ST_ARMED: begin
                    if (isRun && (ov1_q || ov2_q)) begin
                        isCollide <= 1'b1;
                        hitWhich  <= {ov2_q, ov1_q};
                        if (hp > DAMAGE) begin
                            hp           <= hp - DAMAGE;
                            state        <= ST_COOLDOWN;
                            cool_cnt     <= COOLDOWN_CYCLES;
                            isInvincible <= 1'b1;
                        end else begin
                            hp           <= 8'd0;
                            state        <= ST_DEAD;
                            isDead       <= 1'b1;
                            isInvincible <= 1'b0;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // The count only advances while the game runs; the last
                    // decrement re-arms and drops invincibility on the same edge.
                    if (isRun) begin
                        if (cool_cnt <= 16'd1) begin
                            cool_cnt     <= 16'd0;
                            state        <= ST_ARMED;
                            isInvincible <= 1'b0;
                        end else begin
                            cool_cnt <= cool_cnt - 16'd1;
                        end
                    end
                end
                ST_DEAD: begin
                    hp           <= 8'd0;
                    isDead       <= 1'b1;
                    isInvincible <= 1'b0;
                end
                default: begin
                    state        <= ST_ARMED;
                    isInvincible <= 1'b0;
                end
            endcase
        end
    end

endmodule
